// File: rtl/eth_tx_framer.sv
// eth_tx_framer: builds one Ethernet frame in the iob_eth buffer through its register port and triggers the send.
// Optional feature macro ETH_TX_PAD_EN: zero-pad payloads shorter than 46 bytes.
`ifndef ETH_ADDR_W
 `define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
 `define ETH_STATUS 0
`endif
`ifndef ETH_SEND
 `define ETH_SEND 1
`endif
`ifndef ETH_TX_NBYTES
 `define ETH_TX_NBYTES 6
`endif
`ifndef ETH_DATA
 `define ETH_DATA 2048
`endif

module eth_tx_framer #(
   parameter int          ETH_ADDR_W   = `ETH_ADDR_W,
   parameter logic [47:0] DST_MAC      = 48'h0,
   parameter logic [47:0] SRC_MAC      = 48'h0,
   parameter logic [15:0] ETH_TYPE     = 16'h0800,
   parameter int          NBYTES_W     = 11,
   parameter int          MAX_NBYTES   = 1500,
   parameter int          POLL_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [NBYTES_W-1:0]   nbytes,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  eth_sel,
   output logic                  eth_we,
   output logic [ETH_ADDR_W-1:0] eth_addr,
   output logic [31:0]           eth_data_in,
   input  logic [31:0]           eth_data_out
);

   localparam int PW = $clog2(POLL_TIMEOUT + 1);
   localparam logic [ETH_ADDR_W-1:0] A_STATUS = ETH_ADDR_W'(`ETH_STATUS);
   localparam logic [ETH_ADDR_W-1:0] A_SEND   = ETH_ADDR_W'(`ETH_SEND);
   localparam logic [ETH_ADDR_W-1:0] A_TXN    = ETH_ADDR_W'(`ETH_TX_NBYTES);
   localparam logic [ETH_ADDR_W-1:0] A_DATA   = ETH_ADDR_W'(`ETH_DATA);
   localparam logic [ETH_ADDR_W-1:0] A_HDR    = ETH_ADDR_W'(30);
   localparam logic [NBYTES_W-1:0]   MAXN     = NBYTES_W'(MAX_NBYTES);
`ifdef ETH_TX_PAD_EN
   localparam logic [NBYTES_W-1:0]   MINN     = NBYTES_W'(46);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_POLL, S_SETLEN, S_HDR, S_PAYLOAD, S_SEND
`ifdef ETH_TX_PAD_EN
      , S_PAD
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [NBYTES_W-1:0]   nb_q, nb_d, cnt_q, cnt_d, eff_len;
   logic [4:0]            hidx_q, hidx_d;
   logic [PW-1:0]         poll_q, poll_d;
   logic                  ph_q, ph_d, rdy_q, rdy_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                  sel_q, sel_d, we_q, we_d;
   logic [ETH_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  to_tail;
   logic                  unused_rd;

   assign unused_rd = ^eth_data_out[31:1];

`ifdef ETH_TX_PAD_EN
   assign eff_len = (nb_q < MINN) ? MINN : nb_q;
`else
   assign eff_len = nb_q;
`endif

   // Header byte i of the 30-byte preamble/SFD/MAC/EtherType block.
   function automatic logic [7:0] hdr_byte(input logic [4:0] i);
      logic [47:0] sh;
      sh = '0;
      if (i < 5'd15)       sh = 48'h55;
      else if (i == 5'd15) sh = 48'hD5;
      else if (i < 5'd22)  sh = DST_MAC >> (8 * (21 - int'(i)));
      else if (i < 5'd28)  sh = SRC_MAC >> (8 * (27 - int'(i)));
      else                 sh = {32'h0, ETH_TYPE} >> (8 * (29 - int'(i)));
      return sh[7:0];
   endfunction

   always_comb begin
      state_d = state_q;
      nb_d    = nb_q;
      cnt_d   = cnt_q;
      hidx_d  = hidx_q;
      poll_d  = poll_q;
      ph_d    = ph_q;
      rdy_d   = rdy_q;
      busy_d  = busy_q;
      err_d   = err_q;
      done_d  = 1'b0;
      sel_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      to_tail = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            nb_d    = nbytes;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_CHECK;
         end
         S_CHECK: if (nb_q > MAXN) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end else begin
            state_d = S_POLL;
            poll_d  = '0;
            ph_d    = 1'b0;
            sel_d   = 1'b1;
            addr_d  = A_STATUS;
         end
         // ph_q=0: first read cycle, status sampled at its end; ph_q=1: second cycle, act on it.
         S_POLL: if (!ph_q) begin
            rdy_d  = eth_data_out[0];
            ph_d   = 1'b1;
            sel_d  = 1'b1;
            addr_d = A_STATUS;
         end else if (rdy_q) begin
            state_d = S_SETLEN;
            sel_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = A_TXN;
            wdata_d = 32'(eff_len);
         end else if (poll_q == PW'(POLL_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end else begin
            poll_d = poll_q + 1'b1;
            ph_d   = 1'b0;
            sel_d  = 1'b1;
            addr_d = A_STATUS;
         end
         S_SETLEN: begin
            state_d = S_HDR;
            hidx_d  = '0;
            sel_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = A_DATA;
            wdata_d = {24'h0, hdr_byte(5'd0)};
         end
         S_HDR: if (hidx_q != 5'd29) begin
            hidx_d  = hidx_q + 5'd1;
            sel_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = A_DATA + ETH_ADDR_W'(hidx_q + 5'd1);
            wdata_d = {24'h0, hdr_byte(hidx_q + 5'd1)};
         end else if (nb_q == '0) begin
            to_tail = 1'b1;
         end else begin
            state_d = S_PAYLOAD;
         end
         S_PAYLOAD: if (cnt_q == nb_q) begin
            to_tail = 1'b1;
         end else if (s_valid) begin
            cnt_d   = cnt_q + 1'b1;
            sel_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = A_DATA + A_HDR + ETH_ADDR_W'(cnt_q);
            wdata_d = {24'h0, s_data};
         end
`ifdef ETH_TX_PAD_EN
         S_PAD: to_tail = 1'b1;
`endif
         S_SEND: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // After the payload: pad positions up to the minimum (if enabled), then trigger the send.
      if (to_tail) begin
`ifdef ETH_TX_PAD_EN
         if (cnt_q < MINN) begin
            state_d = S_PAD;
            cnt_d   = cnt_q + 1'b1;
            sel_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = A_DATA + A_HDR + ETH_ADDR_W'(cnt_q);
            wdata_d = '0;
         end else
`endif
         begin
            state_d = S_SEND;
            sel_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = A_SEND;
            wdata_d = 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         nb_q    <= '0;
         cnt_q   <= '0;
         hidx_q  <= '0;
         poll_q  <= '0;
         ph_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         sel_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         nb_q    <= nb_d;
         cnt_q   <= cnt_d;
         hidx_q  <= hidx_d;
         poll_q  <= poll_d;
         ph_q    <= ph_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign s_ready     = (state_q == S_PAYLOAD) && (cnt_q < nb_q);
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign eth_sel     = sel_q;
   assign eth_we      = we_q;
   assign eth_addr    = addr_q;
   assign eth_data_in = wdata_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized scoreboard bench for eth_tx_framer: expected bus writes are queued per frame,
// a negedge monitor pops and compares them and models the iob_eth status register.
`ifndef ETH_ADDR_W
 `define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
 `define ETH_STATUS 0
`endif
`ifndef ETH_SEND
 `define ETH_SEND 1
`endif
`ifndef ETH_TX_NBYTES
 `define ETH_TX_NBYTES 6
`endif
`ifndef ETH_DATA
 `define ETH_DATA 2048
`endif

module tb_eth_tx_framer;
   localparam int          AW   = `ETH_ADDR_W;
   localparam logic [47:0] DST  = 48'h0123_4567_89AB;
   localparam logic [47:0] SRC  = 48'hDEAD_BEEF_0042;
   localparam logic [15:0] TYPE = 16'h88B5;
   localparam logic [AW-1:0] A_DATA = AW'(`ETH_DATA);
   localparam logic [AW-1:0] A_TXN  = AW'(`ETH_TX_NBYTES);
   localparam logic [AW-1:0] A_SEND = AW'(`ETH_SEND);

   logic clk = 1'b0, resetn = 1'b0, start = 1'b0, s_valid = 1'b0;
   logic [10:0] nbytes = '0;
   logic [7:0]  s_data = '0;
   logic [31:0] eth_data_out = '0;
   logic s_ready, busy, done, err, eth_sel, eth_we;
   logic [AW-1:0] eth_addr;
   logic [31:0]   eth_data_in;

   typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
   wr_t      exp_q[$];
   logic [7:0] pay_q[$];
   int tests = 0, fails = 0;
   int nreads, nwrites, ndone, rd_after_wr, status_delay, gap_mode, gcyc;
   bit rd_ph = 0, hdr20_seen = 0;
   string msg = "Hello from PC!";

   eth_tx_framer #(.DST_MAC(DST), .SRC_MAC(SRC), .ETH_TYPE(TYPE)) dut (
      .clk(clk), .resetn(resetn), .start(start), .nbytes(nbytes),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .busy(busy), .done(done), .err(err),
      .eth_sel(eth_sel), .eth_we(eth_we), .eth_addr(eth_addr),
      .eth_data_in(eth_data_in), .eth_data_out(eth_data_out));

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Bus monitor: scoreboard for writes, status-register model for reads.
   always @(negedge clk) begin
      if (resetn) begin
         if (done) ndone++;
         if (eth_sel && eth_we) begin
            nwrites++;
            rd_ph = 0;
            if (eth_addr == A_DATA + AW'(20)) hdr20_seen = 1;
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", eth_addr, eth_data_in);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", longint'(eth_addr), longint'(e.addr));
               check("wr_data", longint'(eth_data_in), longint'(e.data));
            end
         end else if (eth_sel) begin
            if (!rd_ph) begin
               if (nwrites != 0) rd_after_wr++;
               eth_data_out = ($urandom & 32'hFFFF_FFFE) | ((nreads >= status_delay) ? 32'd1 : 32'd0);
               nreads++;
               rd_ph = 1;
            end else rd_ph = 0;
         end else rd_ph = 0;
      end
   end

   // Payload source with per-frame gap pattern.
   always @(negedge clk) begin
      if (pay_q.size() > 0) begin
         case (gap_mode)
            0:       s_valid = 1'b1;
            1:       s_valid = ((gcyc / 3) % 2) == 0;
            default: s_valid = ($urandom % 4) != 0;
         endcase
         gcyc++;
         s_data = s_valid ? pay_q[0] : 8'($urandom);
      end else s_valid = 1'b0;
      #1;
      if (s_valid && s_ready && pay_q.size() > 0) void'(pay_q.pop_front());
   end

   // Reference model: frame = 15x55, D5, DST, SRC, TYPE, payload (+pad), as bus writes.
   task automatic expect_frame(input logic [7:0] pl[$]);
      logic [7:0]  fr[$];
      logic [47:0] d, s;
      logic [15:0] t;
      int eff;
      d = DST; s = SRC; t = TYPE;
      repeat (15) fr.push_back(8'h55);
      fr.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) fr.push_back(d[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fr.push_back(s[8*i +: 8]);
      fr.push_back(t[15:8]);
      fr.push_back(t[7:0]);
      foreach (pl[i]) fr.push_back(pl[i]);
      eff = pl.size();
`ifdef ETH_TX_PAD_EN
      while (eff < 46) begin fr.push_back(8'h00); eff++; end
`endif
      exp_q.push_back('{addr: A_TXN, data: 32'(eff)});
      foreach (fr[i]) exp_q.push_back('{addr: A_DATA + AW'(i), data: {24'h0, fr[i]}});
      exp_q.push_back('{addr: A_SEND, data: 32'd1});
   endtask

   task automatic pulse_start(input int n);
      @(negedge clk); start = 1'b1; nbytes = 11'(n);
      @(negedge clk); start = 1'b0;
   endtask

   task automatic clear_counts();
      nreads = 0; nwrites = 0; ndone = 0; rd_after_wr = 0; gcyc = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c;
      c = 0;
      while (busy && c < budget) begin @(negedge clk); c++; end
      if (busy) begin
         tests++; fails++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_frame(input string name, input int n, input int delay, input int gm,
                            input bit ascii, input bit restart_mid);
      logic [7:0] pl[$];
      for (int i = 0; i < n; i++) pl.push_back(ascii ? 8'(msg[i]) : 8'($urandom));
      expect_frame(pl);
      clear_counts();
      status_delay = delay; gap_mode = gm;
      pay_q = pl;
      pulse_start(n);
      check({name, "_busy"}, busy, 1);
      check({name, "_err_clr"}, err, 0);
      if (restart_mid) begin
         repeat (12) @(negedge clk);
         start = 1'b1; nbytes = 11'd5;
         @(negedge clk); start = 1'b0;
      end
      wait_idle(name, 20000);
      check({name, "_done"}, ndone, 1);
      check({name, "_reads"}, nreads, delay + 1);
      check({name, "_rd_after_wr"}, rd_after_wr, 0);
      check({name, "_missing_wr"}, exp_q.size(), 0);
      check({name, "_err"}, err, 0);
      exp_q.delete();
   endtask

   initial begin
      status_delay = 0; gap_mode = 0; clear_counts();
      #3;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_sel", eth_sel, 0);
      check("rst_we", eth_we, 0);
      check("rst_addr", eth_addr, 0);
      check("rst_wdata", eth_data_in, 0);
      check("rst_ready", s_ready, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      run_frame("ready", 14, 0, 0, 1, 0);
      run_frame("delayed", 14, 5, 0, 1, 0);

      clear_counts();
      status_delay = 1 << 30;
      pulse_start(20);
      wait_idle("timeout", 5000);
      check("timeout_err", err, 1);
      check("timeout_reads", nreads, 1024);
      check("timeout_done", ndone, 0);
      check("timeout_writes", nwrites, 0);

      run_frame("gaps", 238, 2, 1, 0, 1);

      clear_counts();
      pulse_start(1501);
      repeat (3) @(negedge clk);
      check("toolong_err", err, 1);
      check("toolong_busy", busy, 0);
      check("toolong_reads", nreads, 0);
      check("toolong_writes", nwrites, 0);
      check("toolong_done", ndone, 0);

      run_frame("zero", 0, 1, 0, 0, 0);
      run_frame("max", 1500, 0, 0, 0, 0);
      run_frame("len45", 45, 0, 2, 0, 0);
      run_frame("len46", 46, 0, 2, 0, 0);

      // Reset while header byte 20 is on the bus.
      expect_frame('{8'hA1, 8'hB2, 8'hC3});
      clear_counts();
      status_delay = 0; hdr20_seen = 0; gap_mode = 0;
      pulse_start(3);
      for (int c = 0; c < 200 && !hdr20_seen; c++) begin @(negedge clk); #1; end
      check("mid_hdr20_seen", hdr20_seen, 1);
      #1 resetn = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sel", eth_sel, 0);
      check("mid_rst_we", eth_we, 0);
      check("mid_rst_addr", eth_addr, 0);
      check("mid_rst_wdata", eth_data_in, 0);
      check("mid_rst_ready", s_ready, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_err", err, 0);
      exp_q.delete(); pay_q.delete(); rd_ph = 0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      nwrites = 0;
      repeat (20) @(negedge clk);
      check("mid_no_send", nwrites, 0);
      check("mid_no_done", ndone, 0);
      run_frame("after_rst", 60, 0, 2, 0, 0);

      for (int k = 0; k < 4; k++)
         run_frame("rand", $urandom_range(1, 120), $urandom_range(0, 3), 2, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Hardware frame sender that drives the iob_eth CPU-side register interface (sel/we/addr/data_in/data_out) in place of a processor.
- Sits directly upstream of iob_eth TX. Accepts a start command plus an 8-bit payload stream.
- Writes preamble, SFD, destination/source MAC and EtherType into the ETH_DATA buffer, then the payload. Programs ETH_TX_NBYTES and issues ETH_SEND.
- Register addresses are the ETH_* macros from iob_eth_defs.vh.

Parameters:
- ETH_ADDR_W, `ETH_ADDR_W: iob_eth register address width.
- DST_MAC, 48'h0: destination MAC, sent MSB byte first.
- SRC_MAC, 48'h0: source MAC, sent MSB byte first.
- ETH_TYPE, 16'h0800: EtherType, sent MSB byte first.
- NBYTES_W, 11: width of the payload length.
- MAX_NBYTES, 1500: largest legal payload length.
- POLL_TIMEOUT, 1024: maximum ETH_STATUS polls before abort.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous reset, active low.
- start  in  1  one-cycle pulse: begin a frame.
- nbytes  in  NBYTES_W  payload length, sampled on start.
- s_valid  in  1  payload byte valid.
- s_data  in  8  payload byte.
- s_ready  out  1  payload byte accepted when s_valid&s_ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after ETH_SEND is written.
- err  out  1  sticky error flag; cleared by the next accepted start.
- eth_sel  out  1  iob_eth select.
- eth_we  out  1  iob_eth write enable.
- eth_addr  out  ETH_ADDR_W  iob_eth address.
- eth_data_in  out  32  write data to iob_eth.
- eth_data_out  in  32  read data from iob_eth.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous, active low.
  - Reset values: every output is 0; FSM is in IDLE.
  - Reset asserted mid-frame aborts immediately. No ETH_SEND is issued. Partially written buffer contents are don't-care.
- Bus outputs: all eth_* outputs are registered.
  - Write access: one cycle with eth_sel=1, eth_we=1, addr and data valid.
  - Read access: two cycles with eth_sel=1, eth_we=0. eth_data_out is sampled at the end of the first cycle.
  - eth_sel=0 between accesses is not required.
- IDLE:
  - start while IDLE: latch nbytes, clear err, busy=1, go to CHECK.
  - start while busy is ignored.
- CHECK:
  - nbytes>MAX_NBYTES: err=1, no bus activity, back to IDLE (busy=0, no done).
  - Otherwise go to POLL.
- POLL:
  - Repeated ETH_STATUS reads until bit0 (TX ready) is 1, then go to SETLEN.
  - Each failed read increments a poll counter. When it reaches POLL_TIMEOUT: err=1, back to IDLE (busy=0, no done).
- SETLEN: write ETH_TX_NBYTES = effective length (see Optional Feature). Go to HDR.
- HDR: 30 consecutive single-cycle writes to ETH_DATA+i, i=0..29. Data is zero-extended to 32 bits.
  - i=0..14: 0x55.
  - i=15: 0xD5.
  - i=16..21: DST_MAC.
  - i=22..27: SRC_MAC.
  - i=28..29: ETH_TYPE.
- PAYLOAD:
  - s_ready=1 only in this state, and only while the byte count < latched nbytes.
  - A byte accepted in cycle N is written to ETH_DATA+30+k in cycle N+1. k counts 0..nbytes-1.
  - Throughput is one byte per cycle. s_valid gaps stall the stream without bus writes.
  - When nbytes==0, PAYLOAD is skipped.
- PAD: only with the optional feature. Writes 0x00 to the remaining positions up to 46.
- SEND: write ETH_SEND to address ETH_SEND. Next cycle: done=1 for one cycle, busy=0, IDLE.
- Counters: the byte counter is NBYTES_W bits and never wraps. The bound is checked in CHECK.

Optional Feature:
- Macro: ETH_TX_PAD_EN.
- Defined: effective length = max(nbytes,46). After the payload, positions nbytes..45 are written 0x00 in PAD, one per cycle. ETH_TX_NBYTES is written with the effective length.
- Undefined: the PAD state does not exist. ETH_TX_NBYTES = nbytes. Lengths below 46 are passed through unchanged.

Test Plan:
- Status ready: after reset, start with nbytes=14 and stream "Hello from PC!"; ETH_STATUS bit0=1.
  Required: 1 status read, then TX_NBYTES=14, bytes 0..29 = the header pattern, bytes 30..43 = the ASCII string, then ETH_SEND; done pulses once.
- Status delayed: ETH_STATUS bit0=0 for 5 reads, then 1.
  Required: exactly 6 reads, no write before the 6th; frame otherwise identical to the first scenario.
- Timeout: ETH_STATUS bit0 held at 0.
  Required: after 1024 reads err=1, busy=0, no done, no writes.
- Stream gaps: nbytes=238, s_valid toggling every 3 cycles.
  Required: 238 payload writes at consecutive addresses 30..267 with no duplicates; TX_NBYTES=238.
- Length and restart edges:
  - nbytes=1501: err=1, zero bus accesses.
  - Then start with nbytes=0: err cleared and the frame is sent. Without ETH_TX_PAD_EN, TX_NBYTES=0. With it, 46 zero pad writes and TX_NBYTES=46.
- Reset mid-frame: deassert resetn during HDR byte 20.
  Required: all outputs 0 asynchronously; no ETH_SEND; a subsequent start produces a complete frame.
